// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared constants, colours, port-B state type and a shift-add
//            constant multiplier for the VGA framebuffer scanout.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int RGB_W      = 3;
    localparam int FB_DEPTH   = FB_W * FB_H;
    localparam int FB_AW      = $clog2(FB_DEPTH);

    localparam logic [RGB_W-1:0] BLACK   = 3'b000;
    localparam logic [RGB_W-1:0] BLUE    = 3'b001;
    localparam logic [RGB_W-1:0] GREEN   = 3'b010;
    localparam logic [RGB_W-1:0] CYAN    = 3'b011;
    localparam logic [RGB_W-1:0] RED     = 3'b100;
    localparam logic [RGB_W-1:0] MAGENTA = 3'b101;
    localparam logic [RGB_W-1:0] YELLOW  = 3'b110;
    localparam logic [RGB_W-1:0] WHITE   = 3'b111;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    // Multiply by a constant as a sum of shifted copies; k folds away at elaboration.
    function automatic logic [31:0] shift_add_mul(input logic [31:0] a, input int k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 31; i++) begin
            if (k[i]) acc = acc + (a << i);
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_fb_ram.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_ram
// Brief    : Single-clock dual-port framebuffer RAM; port A synchronous read,
//            port B write (plus read when VGA_FB_RDBACK_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          clk_master,
    input  logic [AW-1:0] i_a_addr,
    output logic [DW-1:0] o_a_q,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_wdata
`ifdef VGA_FB_RDBACK_EN
    ,
    output logic [DW-1:0] o_b_q
`endif
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    // Read-before-write: a same-address collision returns the old word on port A.
    always_ff @(posedge clk_master) begin
        o_a_q <= r_mem[i_a_addr];
    end

    always_ff @(posedge clk_master) begin
        if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
`ifdef VGA_FB_RDBACK_EN
        o_b_q <= r_mem[i_b_addr];
`endif
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_scanout
// Brief    : 160x120 3-bit framebuffer upscaled x4 for VGA scanout, with a CPU
//            write port and a full-buffer clear engine. Define VGA_FB_RDBACK_EN
//            to add a CPU read-back port sharing RAM port B.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int RGB_W      = 3
) (
    input  logic             clk_master,
    input  logic             rst_n,
    input  logic             px_active,
    input  logic [9:0]       px_x,
    input  logic [9:0]       px_y,
    output logic [RGB_W-1:0] px_rgb,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_x,
    input  logic [6:0]       wr_y,
    input  logic [RGB_W-1:0] wr_rgb,
    output logic             wr_drop,
    input  logic             clr_start,
    input  logic [RGB_W-1:0] clr_rgb,
    output logic             clr_busy,
    output logic             clr_done
`ifdef VGA_FB_RDBACK_EN
    ,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [7:0]       rd_x,
    input  logic [6:0]       rd_y,
    output logic [RGB_W-1:0] rd_rgb,
    output logic             rd_rvalid
`endif
);

    localparam int c_depth = FB_W * FB_H;
    localparam int c_aw    = $clog2(c_depth);
    localparam logic [c_aw-1:0] c_last = c_aw'(c_depth - 1);

    // ---------------- scanout address path ----------------
    logic             w_px_in_area;
    logic [9:0]       w_px_row;
    logic [9:0]       w_px_col;
    logic [31:0]      w_a_prod;
    logic [c_aw-1:0]  w_a_addr;
    logic [c_aw-1:0]  r_a_addr;
    logic             r_active_d1;
    logic             r_active_d2;
    logic [RGB_W-1:0] w_a_q;

    assign w_px_in_area = px_active && (px_x < 10'(H_ACTIVE)) && (px_y < 10'(V_ACTIVE));
    assign w_px_row     = px_y >> SCALE_LOG2;
    assign w_px_col     = px_x >> SCALE_LOG2;
    assign w_a_prod     = shift_add_mul(32'(w_px_row), FB_W) + 32'(w_px_col);
    assign w_a_addr     = w_a_prod[c_aw-1:0];

    always_ff @(posedge clk_master or negedge rst_n) begin
        if (!rst_n) begin
            r_a_addr    <= '0;
            r_active_d1 <= 1'b0;
            r_active_d2 <= 1'b0;
            px_rgb      <= '0;
        end else begin
            r_a_addr    <= w_a_addr;
            r_active_d1 <= w_px_in_area;
            r_active_d2 <= r_active_d1;
            px_rgb      <= r_active_d2 ? w_a_q : '0;
        end
    end

    // ---------------- port B: clear, write, read-back ----------------
    fb_state_t        r_state;
    logic [c_aw-1:0]  r_clr_cnt;
    logic [RGB_W-1:0] r_clr_rgb;
    logic             w_wr_fire;
    logic             w_wr_in_range;
    logic [31:0]      w_wr_prod;
    logic [c_aw-1:0]  w_wr_addr;
    logic             w_b_we;
    logic [c_aw-1:0]  w_b_addr;
    logic [RGB_W-1:0] w_b_wdata;

    assign wr_ready      = (r_state == IDLE) && !clr_start;
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
    assign w_wr_prod     = shift_add_mul(32'(wr_y), FB_W) + 32'(wr_x);
    assign w_wr_addr     = w_wr_prod[c_aw-1:0];

`ifdef VGA_FB_RDBACK_EN
    logic             w_rd_fire;
    logic             w_rd_in_range;
    logic [31:0]      w_rd_prod;
    logic [c_aw-1:0]  w_rd_addr;
    logic [RGB_W-1:0] w_b_q;
    logic             r_rd_d1;
    logic             r_rd_in_range_d1;

    assign rd_ready      = wr_ready && !wr_valid;
    assign w_rd_fire     = rd_valid && rd_ready;
    assign w_rd_in_range = (rd_x < 8'(FB_W)) && (rd_y < 7'(FB_H));
    assign w_rd_prod     = shift_add_mul(32'(rd_y), FB_W) + 32'(rd_x);
    assign w_rd_addr     = w_rd_prod[c_aw-1:0];

    always_ff @(posedge clk_master or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_d1          <= 1'b0;
            r_rd_in_range_d1 <= 1'b0;
            rd_rvalid        <= 1'b0;
            rd_rgb           <= '0;
        end else begin
            r_rd_d1          <= w_rd_fire;
            r_rd_in_range_d1 <= w_rd_in_range;
            rd_rvalid        <= r_rd_d1;
            rd_rgb           <= (r_rd_d1 && r_rd_in_range_d1) ? w_b_q : '0;
        end
    end
`endif

    // Clear owns port B outright; otherwise a write wins over a read.
    always_comb begin
        w_b_we    = 1'b0;
        w_b_addr  = w_wr_addr;
        w_b_wdata = wr_rgb;
        if (r_state == CLEAR) begin
            w_b_we    = 1'b1;
            w_b_addr  = r_clr_cnt;
            w_b_wdata = r_clr_rgb;
        end else if (w_wr_fire) begin
            w_b_we    = w_wr_in_range;
        end
`ifdef VGA_FB_RDBACK_EN
        else if (w_rd_fire) begin
            w_b_addr  = w_rd_addr;
        end
`endif
    end

    always_ff @(posedge clk_master or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
            r_clr_rgb <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            wr_drop  <= w_wr_fire && !w_wr_in_range;
            case (r_state)
                IDLE: begin
                    if (clr_start) begin
                        r_clr_rgb <= clr_rgb;
                        r_clr_cnt <= '0;
                        r_state   <= CLEAR;
                        clr_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_clr_cnt == c_last) begin
                        r_state  <= IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + c_aw'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    vga_fb_ram #(
        .DEPTH (c_depth),
        .AW    (c_aw),
        .DW    (RGB_W)
    ) u_ram (
        .clk_master (clk_master),
        .i_a_addr   (r_a_addr),
        .o_a_q      (w_a_q),
        .i_b_we     (w_b_we),
        .i_b_addr   (w_b_addr),
        .i_b_wdata  (w_b_wdata)
`ifdef VGA_FB_RDBACK_EN
        ,
        .o_b_q      (w_b_q)
`endif
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_scanout
// Brief    : Scoreboard bench for vga_fb_scanout: a framebuffer model predicts
//            each scanout pixel, compared three edges after it is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_scanout;

    logic       clk_master = 1'b0;
    logic       rst_n      = 1'b0;
    logic       px_active  = 1'b0;
    logic [9:0] px_x       = '0;
    logic [9:0] px_y       = '0;
    logic [2:0] px_rgb;
    logic       wr_valid   = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_x       = '0;
    logic [6:0] wr_y       = '0;
    logic [2:0] wr_rgb     = '0;
    logic       wr_drop;
    logic       clr_start  = 1'b0;
    logic [2:0] clr_rgb    = '0;
    logic       clr_busy;
    logic       clr_done;
`ifdef VGA_FB_RDBACK_EN
    logic       rd_valid   = 1'b0;
    logic       rd_ready;
    logic [7:0] rd_x       = '0;
    logic [6:0] rd_y       = '0;
    logic [2:0] rd_rgb;
    logic       rd_rvalid;
`endif

    vga_fb_scanout u_dut (
        .clk_master (clk_master),
        .rst_n      (rst_n),
        .px_active  (px_active),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_rgb     (px_rgb),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_rgb     (wr_rgb),
        .wr_drop    (wr_drop),
        .clr_start  (clr_start),
        .clr_rgb    (clr_rgb),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
`ifdef VGA_FB_RDBACK_EN
        ,
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_rgb     (rd_rgb),
        .rd_rvalid  (rd_rvalid)
`endif
    );

    always #5 clk_master = ~clk_master;

    typedef struct {
        logic [2:0] exp;
        int         due;
        int         x;
        int         y;
    } sb_t;

    sb_t        sb_q[$];
    logic [2:0] model [0:19199];
    int         cyc      = 0;
    int         done_cnt = 0;
    int         n_tests  = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk_master) cyc <= cyc + 1;

    always @(negedge clk_master) begin
        if (clr_done === 1'b1) done_cnt++;
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            sb_t e;
            e = sb_q.pop_front();
            chk($sformatf("px(%0d,%0d)", e.x, e.y), 32'(px_rgb), 32'(e.exp));
        end
    end

    task automatic px_drive(input int x, input int y, input bit act);
        sb_t e;
        @(negedge clk_master);
        px_active = act;
        px_x      = 10'(x);
        px_y      = 10'(y);
        e.x   = x;
        e.y   = y;
        e.due = cyc + 3;
        e.exp = (act && x < 640 && y < 480) ? model[(y / 4) * 160 + (x / 4)] : 3'd0;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk_master);
        px_active = 1'b0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk_master);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("sb_drain", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic wr_pix(input int x, input int y, input logic [2:0] rgb);
        int  n    = 0;
        bit  drop = (x >= 160) || (y >= 120);
        @(negedge clk_master);
        wr_valid = 1'b1;
        wr_x     = 8'(x);
        wr_y     = 7'(y);
        wr_rgb   = rgb;
        #1;
        while (wr_ready !== 1'b1 && n < 100) begin
            @(negedge clk_master);
            n++;
        end
        chk($sformatf("wr_ready(%0d,%0d)", x, y), 32'(wr_ready), 32'd1);
        @(negedge clk_master);
        wr_valid = 1'b0;
        chk($sformatf("wr_drop(%0d,%0d)", x, y), 32'(wr_drop), 32'(drop));
        if (drop) begin
            @(negedge clk_master);
            chk("wr_drop_pulse_end", 32'(wr_drop), 32'd0);
        end else begin
            model[y * 160 + x] = rgb;
        end
    endtask

    // hold_wr presents a write in the same cycle as clr_start and holds it through the clear.
    task automatic run_clear(input logic [2:0] col, input bit hold_wr);
        int n    = 0;
        int rdy  = 0;
        int done0;
        @(negedge clk_master);
        if (hold_wr) begin
            wr_valid = 1'b1;
            wr_x     = 8'd3;
            wr_y     = 7'd2;
            wr_rgb   = 3'h6;
        end
        clr_start = 1'b1;
        clr_rgb   = col;
        #1;
        chk("ready_with_clr_start", 32'(wr_ready), 32'd0);
        done0 = done_cnt;
        @(negedge clk_master);
        clr_start = 1'b0;
        while (clr_busy === 1'b1 && n < 20000) begin
            n++;
            if (wr_ready !== 1'b0) rdy++;
            @(negedge clk_master);
        end
        chk("clr_busy_cycles", 32'(n), 32'd19200);
        chk("clr_ready_during_busy", 32'(rdy), 32'd0);
        chk("clr_done_at_end", 32'(clr_done), 32'd1);
        chk("ready_after_clear", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 19200; i++) model[i] = col;
        @(negedge clk_master);
        chk("clr_done_once", 32'(done_cnt - done0), 32'd1);
        if (hold_wr) begin
            wr_valid = 1'b0;
            chk("held_wr_drop", 32'(wr_drop), 32'd0);
            model[2 * 160 + 3] = 3'h6;
        end
    endtask

`ifdef VGA_FB_RDBACK_EN
    task automatic rd_pix(input int x, input int y, input logic [2:0] exp);
        int n = 0;
        @(negedge clk_master);
        rd_valid = 1'b1;
        rd_x     = 8'(x);
        rd_y     = 7'(y);
        #1;
        while (rd_ready !== 1'b1 && n < 100) begin
            @(negedge clk_master);
            n++;
        end
        chk("rd_ready", 32'(rd_ready), 32'd1);
        @(negedge clk_master);
        rd_valid = 1'b0;
        chk("rd_rvalid_early", 32'(rd_rvalid), 32'd0);
        @(negedge clk_master);
        chk("rd_rvalid", 32'(rd_rvalid), 32'd1);
        chk($sformatf("rd_rgb(%0d,%0d)", x, y), 32'(rd_rgb), 32'(exp));
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done0;
        // Reset state
        repeat (3) @(negedge clk_master);
        chk("rst_px_rgb", 32'(px_rgb), 32'd0);
        chk("rst_wr_drop", 32'(wr_drop), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;

        // Clear to colour 1, then sweep every stored pixel at varied sub-pixel offsets
        run_clear(3'h1, 1'b0);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                px_drive(x * 4 + ((x + y) & 3), y * 4 + ((x ^ y) & 3), 1'b1);
        drain();

        // Corners, plus inactive / out-of-area coordinates
        wr_pix(0, 0, 3'h4);
        wr_pix(159, 119, 3'h2);
        px_drive(0, 0, 1'b1);
        px_drive(639, 479, 1'b1);
        px_drive(640, 0, 1'b1);
        px_drive(0, 480, 1'b1);
        px_drive(0, 0, 1'b0);
        drain();

        // Upscaled 4x4 block and its neighbours
        wr_pix(10, 5, 3'h7);
        for (int y = 20; y < 24; y++)
            for (int x = 40; x < 44; x++)
                px_drive(x, y, 1'b1);
        px_drive(44, 20, 1'b1);
        px_drive(39, 23, 1'b1);
        px_drive(40, 24, 1'b1);
        drain();

        // Out-of-range write is dropped; row 0 and the aliased (0,1) stay untouched
        wr_pix(160, 0, 3'h7);
        for (int x = 0; x < 640; x += 3) px_drive(x, 1, 1'b1);
        px_drive(0, 4, 1'b1);
        px_drive(2, 6, 1'b1);
        drain();

        // Write collides with clr_start: clear first, held write lands right after
        run_clear(3'h2, 1'b1);
        for (int x = 12; x < 17; x++) px_drive(x, 8, 1'b1);
        px_drive(11, 9, 1'b1);
        drain();

`ifdef VGA_FB_RDBACK_EN
        rd_pix(3, 2, 3'h6);
        rd_pix(4, 2, 3'h2);
        rd_pix(160, 0, 3'h0);
`endif

        // Reset in the middle of a clear
        @(negedge clk_master);
        clr_start = 1'b1;
        clr_rgb   = 3'h5;
        @(negedge clk_master);
        clr_start = 1'b0;
        px_active = 1'b1;
        px_x      = 10'd0;
        px_y      = 10'd0;
        repeat (5000) @(negedge clk_master);
        chk("mid_clear_busy", 32'(clr_busy), 32'd1);
        chk("mid_clear_px", 32'(px_rgb), 32'd5);
        done0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(clr_busy), 32'd0);
        chk("async_rst_px", 32'(px_rgb), 32'd0);
        chk("async_rst_done", 32'(clr_done), 32'd0);
        repeat (2) @(negedge clk_master);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_master);
        chk("no_done_after_rst", 32'(done_cnt - done0), 32'd0);
        chk("idle_after_rst", 32'(clr_busy), 32'd0);
        chk("ram_kept_after_rst", 32'(px_rgb), 32'd5);
        px_active = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
